switch_debounce: RTL



---
 rtl/switch_debounce.sv | 81 ++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus per-bit tick-based debounce for the DIP-switch lines.
// Keeps raw pull-up polarity (open switch = 1); the downstream read module inverts.
//
// Per-bit state is encoded by its counter:
//   state    | meaning
//   IDLE     | count = 0, sync matches switch_db (or interval just restarted)
//   COUNTING | sync differs from switch_db, counting sample ticks toward STABLE
module switch_debounce #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 50000,
    parameter int STABLE   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_db,
    output logic             switch_changed,
    output logic             switch_event,
    input  logic             switch_event_clr
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE);
    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [PW-1:0]            pre_q, pre_d;
    logic                     tick;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         db_q, db_d;
    logic                     changed_q, changed_d;
    logic                     event_q, event_d;

    assign tick  = (pre_q == PS_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            // Any matching sample restarts the interval, tick or not.
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick && (cnt_q[i] == CNT_LAST)) begin
                db_d[i]  = ~db_q[i];
                cnt_d[i] = '0;
            end else if (tick) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        changed_d = |(db_d ^ db_q);
        // Set has priority over clear so a change is never lost.
        event_d   = changed_q | (event_q & ~switch_event_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            pre_q     <= '0;
            cnt_q     <= '0;
            db_q      <= '1;
            changed_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            sync1_q   <= switch_raw;
            sync2_q   <= sync1_q;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            changed_q <= changed_d;
            event_q   <= event_d;
        end
    end

    assign switch_db      = db_q;
    assign switch_changed = changed_q;
    assign switch_event   = event_q;

endmodule
